// File: rtl/pulse_burst_tx.sv
// ----------------------------------------------------------------------------
// pulse_burst_tx: drives the toggle-FSM receiver's din high for 2*count cycles,
// then low for a settle gap, then reports done.        Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pulse_burst_tx #(
  parameter int CNT_W      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             line_out,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state_o
);

  localparam logic [2:0] S_IDLE = 3'b001;
  localparam logic [2:0] S_HIGH = 3'b010;
  localparam logic [2:0] S_GAP  = 3'b100;

  localparam int               GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] C_GC_LOAD = GAP_W'(GAP_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W:0]   hc_q, hc_d;
  logic [GAP_W-1:0] gc_q, gc_d;
  logic             line_q, line_d;
  logic             done_q, done_d;
  logic             accept_w;
  logic             nonzero_w;

  assign accept_w  = cmd_valid && (state_q == S_IDLE);
  assign nonzero_w = (cmd_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hc_q    <= '0;
      gc_q    <= '0;
      line_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      gc_q    <= gc_d;
      line_q  <= line_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_w && nonzero_w) state_d = S_HIGH;
      S_HIGH:  if (hc_q == '0) state_d = S_GAP;
      S_GAP:   if (gc_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // hc is one bit wider than cmd_count so 2*N-1 never overflows at the maximum count.
  always_comb begin
    hc_d   = hc_q;
    gc_d   = gc_q;
    line_d = line_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_w && nonzero_w) begin
          line_d = 1'b1;
          hc_d   = {cmd_count, 1'b0} - (CNT_W+1)'(1);
        end else if (accept_w) begin
          done_d = 1'b1;
        end
      end
      S_HIGH: begin
        if (hc_q == '0) begin
          line_d = 1'b0;
          gc_d   = C_GC_LOAD;
        end else begin
          hc_d = hc_q - (CNT_W+1)'(1);
        end
      end
      S_GAP: begin
        line_d = 1'b0;
        if (gc_q == '0) done_d = 1'b1;
        else            gc_d   = gc_q - GAP_W'(1);
      end
      default: begin
        line_d = 1'b0;
        hc_d   = '0;
        gc_d   = '0;
      end
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = !cmd_ready;
  assign line_out  = line_q;
  assign done      = done_q;
  assign state_o   = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_burst_tx.sv
// ----------------------------------------------------------------------------
// tb_pulse_burst_tx: directed bench for pulse_burst_tx with a receiver model.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pulse_burst_tx;

  localparam int CNT_W = 8;
  localparam int GAP   = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_count = '0;
  logic             line_out;
  logic             busy;
  logic             done;
  logic [2:0]       state_o;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  pulse_burst_tx #(.CNT_W(CNT_W), .GAP_CYCLES(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_count (cmd_count),
    .line_out  (line_out),
    .busy      (busy),
    .done      (done),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  // Receiver: idle -> s0 -> s1, one dout pulse per s1->s0 step with din high.
  localparam logic [1:0] RX_IDLE = 2'd0, RX_S0 = 2'd1, RX_S1 = 2'd2;
  logic [1:0] rx_state;
  int         rx_pulses = 0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
    end else begin
      case (rx_state)
        RX_IDLE: rx_state <= RX_S0;
        RX_S0:   if (line_out) rx_state <= RX_S1;
        RX_S1:   if (line_out) begin
                   rx_state  <= RX_S0;
                   rx_pulses <= rx_pulses + 1;
                 end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    check("onehot", int'($onehot(state_o)), 1);
    check("busy_vs_ready", int'(busy), int'(!cmd_ready));
    check("ready_vs_idle", int'(cmd_ready), int'(state_o == 3'b001));
    if (done) done_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int n);
    cmd_valid = 1'b1;
    cmd_count = CNT_W'(n);
    tick;
    cmd_valid = 1'b0;
  endtask

  // Called in cycle 1 after accept; offers a competing count-7 command while busy.
  task automatic measure(input int noise, output int highs, output int lows, output int done_at);
    highs = 0; lows = 0; done_at = 0;
    for (int c = 1; c <= 1000; c++) begin
      cmd_valid = (c <= noise);
      if (c <= noise) cmd_count = 8'd7;
      if (done) begin
        done_at = c;
        break;
      end
      if (line_out) highs++;
      else          lows++;
      tick;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic burst(input string tag, input int n, input int noise);
    int h, l, d, p0;
    p0 = rx_pulses;
    start(n);
    measure(noise, h, l, d);
    check({tag, "_highs"}, h, 2 * n);
    check({tag, "_lows"}, l, GAP);
    check({tag, "_done_at"}, d, 2 * n + GAP + 1);
    check({tag, "_rx_pulses"}, rx_pulses - p0, n);
    check({tag, "_rx_s0"}, int'(rx_state), int'(RX_S0));
    check({tag, "_ready"}, int'(cmd_ready), 1);
    tick;
    check({tag, "_done_1cyc"}, int'(done), 0);
    check({tag, "_line_idle"}, int'(line_out), 0);
  endtask

  initial begin
    int d0;

    // Reset state
    tick;
    check("rst_state", int'(state_o), 1);
    check("rst_line", int'(line_out), 0);
    check("rst_done", int'(done), 0);
    check("rst_ready", int'(cmd_ready), 1);
    tick;
    rst = 1'b0;
    tick;

    // 1: count=3 with ignored commands during the burst
    burst("t1", 3, 3);

    // 2: count=0
    d0 = done_cnt;
    start(0);
    check("t2_done", int'(done), 1);
    check("t2_state", int'(state_o), 1);
    check("t2_line", int'(line_out), 0);
    tick;
    check("t2_done_clr", int'(done), 0);
    check("t2_line2", int'(line_out), 0);
    check("t2_done_count", done_cnt - d0, 1);

    // 3: valid held with count=1; the done/IDLE cycle adds one low to the gap
    d0 = done_cnt;
    cmd_valid = 1'b1;
    cmd_count = 8'd1;
    tick;
    for (int c = 1; c <= 15; c++) begin
      check("t3_line", int'(line_out), int'((c % 5 == 1) || (c % 5 == 2)));
      check("t3_done", int'(done), int'(c % 5 == 0));
      if (c % 5 == 0) check("t3_rx_s0", int'(rx_state), int'(RX_S0));
      if (c == 15) cmd_valid = 1'b0;
      tick;
    end
    check("t3_done_count", done_cnt - d0, 3);
    check("t3_idle", int'(state_o), 1);
    check("t3_line_end", int'(line_out), 0);

    // 4: reset mid-burst, then a clean count=2 burst
    start(5);
    for (int c = 1; c <= 4; c++) begin
      check("t4_high", int'(line_out), 1);
      tick;
    end
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("t4_rst_line", int'(line_out), 0);
    check("t4_rst_state", int'(state_o), 1);
    check("t4_rst_busy", int'(busy), 0);
    tick;
    tick;
    rst = 1'b0;
    tick;
    tick;
    check("t4_no_done", done_cnt - d0, 0);
    burst("t4", 2, 0);

    // 5: maximum count
    burst("t5", 255, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
